// File: rtl/stack_sequencer.sv
// Command sequencer for the hardware stack. Each accepted command is expanded
// into the push/pop sequence the stack needs; one response is returned per command.
module stack_sequencer #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          busy,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [DW-1:0] stk_din,
  input  logic [DW-1:0] stk_dout,
  input  logic [15:0]   stk_tos
);

  typedef enum logic [2:0] {
    StIdle, StPopA, StPopB, StCapt, StPush1, StPush2, StResp
  } state_e;

  typedef enum logic [2:0] {
    OpNop  = 3'd0,
    OpPush = 3'd1,
    OpPop  = 3'd2,
    OpAdd  = 3'd3,
    OpSub  = 3'd4,
    OpDup  = 3'd5,
    OpSwap = 3'd6,
    OpRsvd = 3'd7
  } op_e;

  localparam logic [15:0] DepthTos = 16'(DEPTH);

  state_e        state_q, state_d;
  op_e           op_q, op_in;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] a_q, b_q;       // a = entry below top, b = top entry
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_load;
  logic          accept;
  logic          cmd_err;
  logic          push, pop;
  logic [DW-1:0] din;
  logic [DW-1:0] alu_r;

  assign op_in     = op_e'(cmd_op);
  assign cmd_ready = (state_q == StIdle) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp) && !rst;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign alu_r     = (op_q == OpSub) ? (a_q - b_q) : (a_q + b_q);

  // Stack-occupancy check for the incoming command
  always_comb begin
    cmd_err = 1'b0;
    case (op_in)
      OpNop:                cmd_err = 1'b0;
      OpPush:               cmd_err = (stk_tos >= DepthTos);
      OpPop:                cmd_err = (stk_tos == 16'd0);
      OpAdd, OpSub, OpSwap: cmd_err = (stk_tos < 16'd2);
      OpDup:                cmd_err = (stk_tos == 16'd0) || (stk_tos >= DepthTos);
      default:              cmd_err = 1'b1;
    endcase
  end

  // Next-state, stack strobes and response capture
  always_comb begin
    state_d    = state_q;
    rsp_load   = 1'b0;
    rsp_data_d = '0;
    rsp_err_d  = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    din        = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (cmd_err) begin
            state_d   = StResp;
            rsp_load  = 1'b1;
            rsp_err_d = 1'b1;
          end else if (op_in == OpNop) begin
            state_d  = StResp;
            rsp_load = 1'b1;
          end else if (op_in == OpPush) begin
            state_d = StPush1;
          end else begin
            state_d = StPopA;
          end
        end
      end
      StPopA: begin
        pop     = 1'b1;
        state_d = (op_q == OpPop || op_q == OpDup) ? StCapt : StPopB;
      end
      StPopB: begin
        pop     = 1'b1;
        state_d = StCapt;
      end
      StCapt: begin
        if (op_q == OpPop) begin
          // Popped value is on stk_dout right now; respond with it directly
          state_d    = StResp;
          rsp_load   = 1'b1;
          rsp_data_d = stk_dout;
        end else begin
          state_d = StPush1;
        end
      end
      StPush1: begin
        push = 1'b1;
        case (op_q)
          OpPush:       din = imm_q;
          OpAdd, OpSub: din = alu_r;
          default:      din = b_q;
        endcase
        if (op_q == OpDup || op_q == OpSwap) begin
          state_d = StPush2;
        end else begin
          state_d    = StResp;
          rsp_load   = 1'b1;
          rsp_data_d = din;
        end
      end
      StPush2: begin
        push       = 1'b1;
        din        = (op_q == OpSwap) ? a_q : b_q;
        state_d    = StResp;
        rsp_load   = 1'b1;
        rsp_data_d = din;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes are forced low while reset is held so an aborted command stops at once
  always_comb begin
    stk_push = push && !rst;
    stk_pop  = pop && !rst;
    stk_din  = (push && !rst) ? din : '0;
  end

  // State, operand and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= OpNop;
      imm_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op_in;
        imm_q <= cmd_data;
      end
      if (state_q == StPopB) begin
        b_q <= stk_dout;
      end
      if (state_q == StCapt) begin
        if (op_q == OpPop || op_q == OpDup) begin
          b_q <= stk_dout;
        end else begin
          a_q <= stk_dout;
        end
      end
      if (rsp_load) begin
        rsp_data_q <= rsp_data_d;
        rsp_err_q  <= rsp_err_d;
      end
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: behavioural 16x16 stack, directed commands, and a
// scoreboard queue checked by a monitor on each response pulse.
module tb_stack_sequencer;

  localparam int DW = 16;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] PUSH = 3'd1;
  localparam logic [2:0] POP  = 3'd2;
  localparam logic [2:0] ADD  = 3'd3;
  localparam logic [2:0] SUB  = 3'd4;
  localparam logic [2:0] DUP  = 3'd5;
  localparam logic [2:0] SWAP = 3'd6;
  localparam logic [2:0] RSVD = 3'd7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'd0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;
  logic          stk_push;
  logic          stk_pop;
  logic [DW-1:0] stk_din;
  logic [DW-1:0] stk_dout;
  logic [15:0]   stk_tos;

  always #5 clk = ~clk;

  stack_sequencer #(.DW(DW), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_din   (stk_din),
    .stk_dout  (stk_dout),
    .stk_tos   (stk_tos)
  );

  // Behavioural stack: dout valid the cycle after a pop, tos updated at the edge
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (rst) begin
      stk_tos  <= 16'd0;
      stk_dout <= '0;
    end else if (stk_push && stk_tos < 16'd16) begin
      mem[stk_tos[3:0]] <= stk_din;
      stk_tos <= stk_tos + 16'd1;
    end else if (stk_pop && stk_tos != 16'd0) begin
      stk_dout <= mem[stk_tos[3:0] - 4'd1];
      stk_tos  <= stk_tos - 16'd1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
    logic [15:0] tos;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];

  // Monitor: every response pulse is matched against the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got data=0x%0h err=%0b, required no response",
                 rsp_data, rsp_err);
      end else begin
        e = sb.pop_front();
        check({e.name, " data"}, 32'(rsp_data), 32'(e.data));
        check({e.name, " err"}, 32'(rsp_err), 32'(e.err));
        check({e.name, " latency"}, 32'(cyc - e.acc), 32'(e.lat));
        check({e.name, " tos"}, 32'(stk_tos), 32'(e.tos));
      end
    end
  end

  // Issue one command; hold cmd_valid with a NOP while busy to show it is ignored
  task automatic send(input string name, input logic [2:0] op, input logic [15:0] data,
                      input logic [15:0] exp_data, input logic exp_err, input int lat,
                      input logic [15:0] exp_tos, input int strobes);
    int n;
    int s;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check({name, " ready_timeout"}, 32'(cmd_ready), 32'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    e.data = exp_data; e.err = exp_err; e.lat = lat; e.tos = exp_tos; e.acc = cyc;
    e.name = name;
    sb.push_back(e);
    @(negedge clk);
    cmd_op   = NOP;
    cmd_data = 16'hdead;
    s = 0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      s += int'(stk_push) + int'(stk_pop);
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    if (!rsp_valid) begin
      check({name, " rsp_timeout"}, 32'(rsp_valid), 32'd1);
      void'(sb.pop_front());
    end
    check({name, " strobes"}, 32'(s), 32'(strobes));
  endtask

  task automatic reset_checks();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_data", 32'(rsp_data), 32'd0);
    check("rst rsp_err", 32'(rsp_err), 32'd0);
    check("rst strobes", 32'({stk_push, stk_pop}), 32'd0);
    check("rst stk_din", 32'(stk_din), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset_checks();

    // Basic add then pop
    send("push5", PUSH, 16'd5, 16'd5, 1'b0, 2, 16'd1, 1);
    send("push3", PUSH, 16'd3, 16'd3, 1'b0, 2, 16'd2, 1);
    send("add",   ADD,  16'd0, 16'd8, 1'b0, 5, 16'd1, 3);
    send("pop8",  POP,  16'd0, 16'd8, 1'b0, 3, 16'd0, 1);

    // Subtract wraps modulo 2^16
    send("push3b", PUSH, 16'd3, 16'd3, 1'b0, 2, 16'd1, 1);
    send("push5b", PUSH, 16'd5, 16'd5, 1'b0, 2, 16'd2, 1);
    send("sub",    SUB,  16'd0, 16'hfffe, 1'b0, 5, 16'd1, 3);
    send("popfffe", POP, 16'd0, 16'hfffe, 1'b0, 3, 16'd0, 1);

    // Underflow errors
    send("pop_empty", POP,  16'd0, 16'd0, 1'b1, 1, 16'd0, 0);
    send("push9",     PUSH, 16'd9, 16'd9, 1'b0, 2, 16'd1, 1);
    send("add_one",   ADD,  16'd0, 16'd0, 1'b1, 1, 16'd1, 0);
    send("swap_one",  SWAP, 16'd0, 16'd0, 1'b1, 1, 16'd1, 0);
    send("rsvd",      RSVD, 16'd0, 16'd0, 1'b1, 1, 16'd1, 0);
    send("pop9",      POP,  16'd0, 16'd9, 1'b0, 3, 16'd0, 1);

    // Fill to capacity, then overflow errors, then drain
    for (int i = 0; i < 16; i++) begin
      send($sformatf("fill%0d", i), PUSH, 16'(i), 16'(i), 1'b0, 2, 16'(i + 1), 1);
    end
    send("push_full", PUSH, 16'd99, 16'd0, 1'b1, 1, 16'd16, 0);
    send("dup_full",  DUP,  16'd0,  16'd0, 1'b1, 1, 16'd16, 0);
    for (int i = 15; i >= 0; i--) begin
      send($sformatf("drain%0d", i), POP, 16'd0, 16'(i), 1'b0, 3, 16'(i), 1);
    end

    // Swap and dup
    send("push1", PUSH, 16'd1, 16'd1, 1'b0, 2, 16'd1, 1);
    send("push2", PUSH, 16'd2, 16'd2, 1'b0, 2, 16'd2, 1);
    send("swap",  SWAP, 16'd0, 16'd1, 1'b0, 6, 16'd2, 4);
    send("pop1",  POP,  16'd0, 16'd1, 1'b0, 3, 16'd1, 1);
    send("pop2",  POP,  16'd0, 16'd2, 1'b0, 3, 16'd0, 1);
    send("push7", PUSH, 16'd7, 16'd7, 1'b0, 2, 16'd1, 1);
    send("dup",   DUP,  16'd0, 16'd7, 1'b0, 5, 16'd2, 3);
    send("pop7a", POP,  16'd0, 16'd7, 1'b0, 3, 16'd1, 1);
    send("pop7b", POP,  16'd0, 16'd7, 1'b0, 3, 16'd0, 1);
    send("nop",   NOP,  16'h55, 16'd0, 1'b0, 1, 16'd0, 0);

    // Reset in the middle of an ADD (during POPB)
    send("push4", PUSH, 16'd4, 16'd4, 1'b0, 2, 16'd1, 1);
    send("push6", PUSH, 16'd6, 16'd6, 1'b0, 2, 16'd2, 1);
    @(negedge clk);
    check("abort ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = ADD;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort popa busy", 32'(busy), 32'd1);
    check("abort popa strobe", 32'(stk_pop), 32'd1);
    check("abort rsp_data hold", 32'(rsp_data), 32'd6);
    @(negedge clk);
    check("abort popb strobe", 32'(stk_pop), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort strobes", 32'({stk_push, stk_pop}), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort cmd_ready in rst", 32'(cmd_ready), 32'd0);
    check("abort tos", 32'(stk_tos), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort cmd_ready after", 32'(cmd_ready), 32'd1);

    // Recovery
    send("nop2",     NOP,  16'd0,     16'd0,     1'b0, 1, 16'd0, 0);
    send("push1234", PUSH, 16'h1234,  16'h1234,  1'b0, 2, 16'd1, 1);
    send("pop1234",  POP,  16'd0,     16'h1234,  1'b0, 3, 16'd0, 1);

    repeat (4) @(negedge clk);
    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Command sequencer for the 16x16 hardware stack of the processor datapath. Accepts stack-machine commands (PUSH, POP, ADD, SUB, DUP, SWAP, NOP) over a valid/ready handshake. Expands each command into the cycle-exact push/pop sequence the stack requires, checks overflow/underflow against the stack's top-of-stack index, and returns one response per command.

## Interface
- DW, 16, data width of the stack and of command/response data
- DEPTH, 16, stack capacity in entries
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high; shared with the stack
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 SUB, 5 DUP, 6 SWAP, 7 reserved
- cmd_data  in  DW  immediate for PUSH; ignored otherwise
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_data  out  DW  command result
- rsp_err  out  1  command rejected; no stack activity occurred
- busy  out  1  state != IDLE
- stk_push  out  1  stack push strobe
- stk_pop  out  1  stack pop strobe
- stk_din  out  DW  stack write data; 0 when stk_push=0
- stk_dout  in  DW  stack read data; valid the cycle after a stk_pop
- stk_tos  in  16  stack entry count, updated at the edge ending a push/pop cycle

## Operation
- States: IDLE, POPA, POPB, CAPT, PUSH1, PUSH2, RESP.
- cmd_ready = (state==IDLE) && !rst. Accept on cmd_valid && cmd_ready; latch op and cmd_data.
- Error check at acceptance, using stk_tos:
  - POP or DUP: requires tos>=1.
  - ADD, SUB or SWAP: requires tos>=2.
  - PUSH: requires tos<DEPTH.
  - DUP: also requires tos<DEPTH.
  - op 7: always an error.
  - On error, go to RESP with rsp_err=1 and rsp_data=0. No stk_push/stk_pop asserted.
- Sequences. b = top entry, a = entry below it.
  - NOP: IDLE -> RESP. rsp_data=0.
  - PUSH: PUSH1 (push cmd_data) -> RESP. rsp_data=cmd_data.
  - POP: POPA (pop) -> CAPT (b<=stk_dout) -> RESP. rsp_data=b.
  - ADD/SUB: POPA (pop) -> POPB (b<=stk_dout, pop) -> CAPT (a<=stk_dout) -> PUSH1 (push r) -> RESP.
    - r = a+b or a-b, truncated mod 2^DW, no carry/borrow flag. rsp_data=r.
  - DUP: POPA -> CAPT (b<=stk_dout) -> PUSH1 (push b) -> PUSH2 (push b) -> RESP. rsp_data=b.
  - SWAP: POPA -> POPB -> CAPT -> PUSH1 (push b) -> PUSH2 (push a) -> RESP. rsp_data=a (new top).
- RESP -> IDLE unconditionally.
- At most one of stk_push/stk_pop is high in any cycle.

## Timing
- Cycle 0 is the acceptance cycle. rsp_valid is high in the cycle listed:
  - NOP/error: cycle 1
  - PUSH: cycle 2
  - POP: cycle 3
  - DUP: cycle 5
  - ADD/SUB: cycle 5
  - SWAP: cycle 6
- Next command is accepted no earlier than the cycle after RESP.
- stk_tos reflects the completed command in the RESP cycle.
- Reset values:
  - state=IDLE
  - rsp_valid=0, rsp_err=0, rsp_data=0
  - stk_push=0, stk_pop=0, stk_din=0
  - busy=0
  - cmd_ready=0 during rst, 1 in the first cycle after rst deasserts
- Reset mid-command: abort immediately, no response issued. Stack contents are invalid (the stack shares rst); stk_tos is 0 after reset.
- rsp_data/rsp_err are held at their last value when rsp_valid=0.
- cmd_valid while busy: ignored, command not consumed.

## Test plan
- Reset; PUSH 5, PUSH 3, ADD -> rsp_data=8, err=0, rsp at cycle 5, tos=1. Then POP -> rsp_data=8, tos=0.
- PUSH 3, PUSH 5, SUB -> rsp_data=0xFFFE (3-5 mod 2^16), tos=1.
- Empty stack: POP -> rsp_err=1 at cycle 1, no stk_pop pulse, tos=0. PUSH 9, then ADD -> err=1, tos stays 1.
- PUSH 0..15 (16 pushes) -> all err=0, tos=16. 17th PUSH -> err=1. DUP at tos=16 -> err=1.
- PUSH 1, PUSH 2, SWAP -> rsp_data=1; POP -> 1; POP -> 2. PUSH 7, DUP -> rsp_data=7, tos=2; two POPs -> 7, 7.
- PUSH 4, PUSH 6, ADD, assert rst during POPB for one cycle -> no rsp_valid, stk strobes 0 from the next cycle, cmd_ready=1 one cycle after release, tos=0.
